// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM state encoding for the memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arbState_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin encoder: first requester after lastGrant, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] lastGrant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(lastGrant) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between NUM_PORTS bus masters.
// Optional MEM_ARB_LOCK_EN adds m_lock so a master can keep the grant across transactions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*ADDR_W-1:0] m_addr,
    input  logic [NUM_PORTS-1:0]        m_rstrb,
    input  logic [NUM_PORTS*MASK_W-1:0] m_wmask,
    input  logic [NUM_PORTS*DATA_W-1:0] m_wdata,
    output logic [NUM_PORTS-1:0]        m_ready,
    output logic [NUM_PORTS-1:0]        m_rvalid,
    output logic [DATA_W-1:0]           m_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_PORTS-1:0]        m_lock,
`endif
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rstrb,
    output logic [MASK_W-1:0]           mem_wmask,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] StIdle  = 2'(IDLE);
    localparam logic [1:0] StIssue = 2'(ISSUE);
    localparam logic [1:0] StRdata = 2'(RDATA);

    logic [1:0]           state;
    logic [IDX_W-1:0]     lastGrant;
    logic [ADDR_W-1:0]    holdAddr;
    logic [DATA_W-1:0]    holdWdata;
    logic [MASK_W-1:0]    holdWmask;
    logic                 holdRead;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] pickOneHot;
    logic [NUM_PORTS-1:0] winOneHot;
    logic [NUM_PORTS-1:0] lastOneHot;
    logic [IDX_W-1:0]     pickIdx;
    logic [IDX_W-1:0]     winIdx;
    logic                 pickAny;

    logic [ADDR_W-1:0]    muxAddr;
    logic [DATA_W-1:0]    muxWdata;
    logic [MASK_W-1:0]    muxWmask;
    logic                 muxRstrb;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = m_rstrb[i] | (|m_wmask[MASK_W*i +: MASK_W]);
        end
    end

    rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) uPicker (
        .req       (req),
        .lastGrant (lastGrant),
        .grant     (pickOneHot),
        .idx       (pickIdx),
        .any       (pickAny)
    );

    assign lastOneHot = NUM_PORTS'(1) << lastGrant;

`ifdef MEM_ARB_LOCK_EN
    // A locked holder that is still requesting pre-empts the round-robin order.
    logic lockHold;
    assign lockHold  = m_lock[lastGrant] & req[lastGrant];
    assign winIdx    = lockHold ? lastGrant  : pickIdx;
    assign winOneHot = lockHold ? lastOneHot : pickOneHot;
`else
    assign winIdx    = pickIdx;
    assign winOneHot = pickOneHot;
`endif

    always_comb begin
        muxAddr  = '0;
        muxWdata = '0;
        muxWmask = '0;
        muxRstrb = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winOneHot[i]) begin
                muxAddr  = muxAddr  | m_addr[ADDR_W*i +: ADDR_W];
                muxWdata = muxWdata | m_wdata[DATA_W*i +: DATA_W];
                muxWmask = muxWmask | m_wmask[MASK_W*i +: MASK_W];
                muxRstrb = muxRstrb | m_rstrb[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StIdle;
            lastGrant <= IDX_W'(NUM_PORTS - 1);
            holdAddr  <= '0;
            holdWdata <= '0;
            holdWmask <= '0;
            holdRead  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (pickAny) begin
                        holdAddr  <= muxAddr;
                        holdWdata <= muxWdata;
                        holdWmask <= muxWmask;
                        // A write mask wins over a simultaneous read strobe.
                        holdRead  <= muxRstrb & ~(|muxWmask);
                        lastGrant <= winIdx;
                        state     <= StIssue;
                    end
                end
                StIssue: state <= holdRead ? StRdata : StIdle;
                StRdata: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign mem_addr  = holdAddr;
    assign mem_wdata = holdWdata;
    assign mem_rstrb = (state == StIssue) & holdRead;
    assign mem_wmask = (state == StIssue) ? holdWmask : '0;

    assign m_ready  = (state == StIssue) ? lastOneHot : '0;
    assign m_rvalid = (state == StRdata) ? lastOneHot : '0;
    assign m_rdata  = (state == StRdata) ? mem_rdata  : '0;

endmodule
